onn_run_sequencer: RTL and testbench

Run controller for the oscillatory neural network core. It accepts one phase pattern at a time from a requester over a valid/ready handshake, clears the network, and shifts the pattern serially into the network's `data_in`/`load` port. It then watches the network's parallel phase bus until the phases hold still for a programmable window, and returns the captured phases with a status code. It sits between the host/pattern source and the ONN top, and owns the ONN's reset, `load` and `data_in` pins.

---
 rtl/onn_run_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_onn_run_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onn_run_sequencer.sv
// onn_run_sequencer: owns ONN reset/load pins, shifts a pattern in, waits for
// phase convergence and returns the captured phases. Option: ONN_SEQ_TIMEOUT_EN.
module onn_run_sequencer #(
    parameter int N          = 210,
    parameter int PW         = 4,
    parameter int LOAD_LEN   = 840,
    parameter int STABLE_CYC = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic                sclk,
    input  logic                re,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [LOAD_LEN-1:0] req_pattern,
    input  logic                abort,
    output logic                onn_rst_n,
    output logic                onn_load,
    output logic                onn_data_in,
    input  logic [PW*N-1:0]     onn_phi,
    input  logic                onn_phi_to_no,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [PW*N-1:0]     res_phi,
    output logic                res_flag,
    output logic [1:0]          res_status,
    output logic [15:0]         res_cycles,
    output logic                busy
);

    localparam int PHW = PW * N;
    localparam int LCW = $clog2(LOAD_LEN + 1);
    localparam int SCW = $clog2(STABLE_CYC + 1);
    localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_LEN - 1);
    localparam logic [SCW-1:0] STB_LAST  = SCW'(STABLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        SETTLE,
        DONE
    } state_t;

    state_t              state;
    logic [LOAD_LEN-1:0] pat_sr;
    logic [LCW-1:0]      cnt;
    logic [PHW-1:0]      prev;
    logic [SCW-1:0]      stable_cnt;
    logic [15:0]         settle_cyc;
    logic [15:0]         settle_nxt;
    logic                same;
    logic                conv;

    // Reject configurations that cannot converge or time out.
    if (STABLE_CYC < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("onn_run_sequencer: STABLE_CYC and TIMEOUT must be >= 1");
    end

`ifdef ONN_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tcnt;
    logic          tmo;
`endif

    // Settle-phase helpers: saturating cycle count and convergence detect.
    always_comb begin
        settle_nxt = (settle_cyc == 16'hFFFF) ? settle_cyc
                                              : settle_cyc + 16'd1;
        same = (onn_phi == prev);
        conv = (settle_cyc != 16'd0) && same && (stable_cnt == STB_LAST);
`ifdef ONN_SEQ_TIMEOUT_EN
        tmo = (tcnt == TMO_LAST);
`endif
    end

    // Run FSM; ONN pins and req_ready follow the state one edge later.
    always_ff @(posedge sclk or negedge re) begin
        if (!re) begin
            state       <= IDLE;
            pat_sr      <= '0;
            cnt         <= '0;
            prev        <= '0;
            stable_cnt  <= '0;
            settle_cyc  <= '0;
            req_ready   <= 1'b1;
            onn_rst_n   <= 1'b0;
            onn_load    <= 1'b0;
            onn_data_in <= 1'b0;
            res_valid   <= 1'b0;
            res_phi     <= '0;
            res_flag    <= 1'b0;
            res_status  <= 2'b00;
            res_cycles  <= '0;
            busy        <= 1'b0;
`ifdef ONN_SEQ_TIMEOUT_EN
            tcnt        <= '0;
`endif
        end else begin
            req_ready <= (state == IDLE);
            onn_rst_n <= (state != CLEAR);
            onn_load  <= (state == LOAD);
            res_valid <= (state == DONE);
            unique case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        pat_sr    <= req_pattern;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + LCW'(1);
                    if (cnt == LCW'(1)) begin
                        cnt   <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    onn_data_in <= pat_sr[LOAD_LEN-1];
                    pat_sr      <= {pat_sr[LOAD_LEN-2:0], 1'b0};
                    cnt         <= cnt + LCW'(1);
                    if (cnt == LOAD_LAST) begin
                        settle_cyc <= '0;
                        stable_cnt <= '0;
`ifdef ONN_SEQ_TIMEOUT_EN
                        tcnt       <= '0;
`endif
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    prev       <= onn_phi;
                    settle_cyc <= settle_nxt;
`ifdef ONN_SEQ_TIMEOUT_EN
                    tcnt       <= tcnt + TW'(1);
`endif
                    if (settle_cyc == 16'd0 || !same)
                        stable_cnt <= '0;
                    else
                        stable_cnt <= stable_cnt + SCW'(1);
                    if (conv) begin
                        res_phi    <= onn_phi;
                        res_flag   <= onn_phi_to_no;
                        res_cycles <= settle_nxt;
                        res_status <= 2'b00;
                        state      <= DONE;
                    end
`ifdef ONN_SEQ_TIMEOUT_EN
                    else if (tmo) begin
                        res_phi    <= onn_phi;
                        res_flag   <= onn_phi_to_no;
                        res_cycles <= settle_nxt;
                        res_status <= 2'b01;
                        state      <= DONE;
                    end
`endif
                end
                DONE: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (abort && state != IDLE) begin
                state     <= IDLE;
                onn_load  <= 1'b0;
                onn_rst_n <= 1'b1;
                res_valid <= 1'b0;
                busy      <= 1'b0;
                req_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_onn_run_sequencer.sv
// tb_onn_run_sequencer: table, random and directed runs of the ONN
// run sequencer against a sample-history convergence model.
module tb_onn_run_sequencer;

    localparam int N   = 8;
    localparam int PW  = 4;
    localparam int LL  = 8;
    localparam int S   = 4;
    localparam int TMO = 32;
    localparam int PHW = PW * N;

    logic           sclk = 1'b0;
    logic           re;
    logic           req_valid;
    logic           req_ready;
    logic [LL-1:0]  req_pattern;
    logic           abort;
    logic           onn_rst_n;
    logic           onn_load;
    logic           onn_data_in;
    logic [PHW-1:0] onn_phi;
    logic           onn_phi_to_no;
    logic           res_valid;
    logic           res_ready;
    logic [PHW-1:0] res_phi;
    logic           res_flag;
    logic [1:0]     res_status;
    logic [15:0]    res_cycles;
    logic           busy;

    int checks = 0;
    int failures = 0;

    logic [PHW-1:0] hist[$];
    logic           fhist[$];

    typedef struct {
        logic [7:0]  pat;
        logic [63:0] chg;
        int          stall;
        int          exp_cyc;
    } vec_t;

    vec_t tbl[5];

    onn_run_sequencer #(
        .N(N), .PW(PW), .LOAD_LEN(LL), .STABLE_CYC(S), .TIMEOUT(TMO)
    ) dut (
        .sclk(sclk), .re(re),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_pattern(req_pattern), .abort(abort),
        .onn_rst_n(onn_rst_n), .onn_load(onn_load),
        .onn_data_in(onn_data_in), .onn_phi(onn_phi),
        .onn_phi_to_no(onn_phi_to_no),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_phi(res_phi), .res_flag(res_flag),
        .res_status(res_status), .res_cycles(res_cycles),
        .busy(busy)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Converged at sample c when the last S+1 samples are identical.
    function automatic void model(output int cyc, output logic [1:0] st);
        cyc = -1;
        st  = 2'b00;
        for (int c = 1; c <= hist.size(); c++) begin
            if (c - 1 >= S) begin
                bool_eq: begin
                    bit eq = 1'b1;
                    for (int j = c - 1 - S; j < c - 1; j++)
                        if (hist[j] !== hist[c-1]) eq = 1'b0;
                    if (eq) begin
                        cyc = c;
                        return;
                    end
                end
            end
`ifdef ONN_SEQ_TIMEOUT_EN
            if (c == TMO) begin
                cyc = TMO;
                st  = 2'b01;
                return;
            end
`endif
        end
    endfunction

    task automatic run(input logic [7:0] pat, input logic [63:0] chg,
                       input int stall, input bit rnd,
                       output int got_cyc, output logic [1:0] got_st);
        int e;
        int got_e;
        int exp_c;
        logic [1:0] exp_s;
        logic [PHW-1:0] ph;
        logic [PHW-1:0] hold_phi;
        logic [15:0] hold_cyc;
        bit done;
        hist.delete();
        fhist.delete();
        got_cyc = -1;
        got_st  = 2'b11;
        e = 0;
        while (!req_ready && e < 50) begin
            @(posedge sclk); #1;
            e++;
        end
        chk("req_ready_pre", req_ready, 1);
        res_ready   = 1'b0;
        req_valid   = 1'b1;
        req_pattern = pat;
        onn_phi     = $urandom;
        ph          = $urandom;
        @(posedge sclk); #1;
        req_valid   = 1'b0;
        req_pattern = ~pat;
        chk("req_ready_acc", req_ready, 0);
        chk("busy_acc", busy, 1);
        done  = 1'b0;
        got_e = 0;
        for (e = 1; e <= 400 && !done; e++) begin
            if (e >= 11) begin
                if (e - 10 >= 2 && e - 10 < 64 && chg[e-10])
                    ph = ph ^ (rnd ? PHW'($urandom | 1) : 32'h5A5A_0F0F);
                onn_phi       = ph;
                onn_phi_to_no = $urandom;
                hist.push_back(ph);
                fhist.push_back(onn_phi_to_no);
            end
            @(posedge sclk); #1;
            if (e <= 2) begin
                chk("clr_rst_n", onn_rst_n, 0);
                chk("clr_load", onn_load, 0);
            end else if (e <= 10) begin
                chk("ld_rst_n", onn_rst_n, 1);
                chk("ld_load", onn_load, 1);
                chk("ld_data", onn_data_in, pat[10-e]);
            end else if (e == 11) begin
                chk("settle_load", onn_load, 0);
            end
            if (res_valid) begin
                done  = 1'b1;
                got_e = e;
            end
        end
        chk("res_valid_seen", done, 1);
        if (!done) return;
        got_cyc = res_cycles;
        got_st  = res_status;
        model(exp_c, exp_s);
        chk("res_cycles", res_cycles, exp_c);
        chk("res_status", res_status, exp_s);
        chk("res_latency", got_e, 11 + exp_c);
        if (exp_c >= 1 && exp_c <= hist.size()) begin
            chk("res_phi", res_phi, hist[exp_c-1]);
            chk("res_flag", res_flag, fhist[exp_c-1]);
        end
        hold_phi = res_phi;
        hold_cyc = res_cycles;
        for (int i = 0; i < stall; i++) begin
            onn_phi = $urandom;
            @(posedge sclk); #1;
            chk("stall_valid", res_valid, 1);
            chk("stall_phi", res_phi, hold_phi);
            chk("stall_cyc", res_cycles, hold_cyc);
        end
        res_ready = 1'b1;
        @(posedge sclk); #1;
        res_ready = 1'b0;
        chk("hs_valid", res_valid, 0);
        chk("hs_busy", busy, 0);
        chk("hs_req_ready", req_ready, 0);
        @(posedge sclk); #1;
        chk("post_req_ready", req_ready, 1);
    endtask

    initial begin
        int gc;
        logic [1:0] gs;
        int seen;
        tbl[0] = '{8'hA5, 64'h0, 0, 5};
        tbl[1] = '{8'h3C, 64'h3C, 0, 9};
        tbl[2] = '{8'hFF, 64'h4, 2, 6};
        tbl[3] = '{8'h01, 64'h7FC, 10, 14};
        tbl[4] = '{8'h80, 64'h44, 0, 10};

        re = 1'b0;
        req_valid = 1'b0;
        req_pattern = '0;
        abort = 1'b0;
        onn_phi = '0;
        onn_phi_to_no = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(posedge sclk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_onn_rst_n", onn_rst_n, 0);
        chk("rst_load", onn_load, 0);
        chk("rst_data", onn_data_in, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_phi", res_phi, 0);
        chk("rst_res_flag", res_flag, 0);
        chk("rst_status", res_status, 0);
        chk("rst_cycles", res_cycles, 0);
        chk("rst_busy", busy, 0);
        re = 1'b1;
        @(posedge sclk); #1;
        chk("rel_onn_rst_n", onn_rst_n, 1);
        chk("rel_req_ready", req_ready, 1);

        abort = 1'b1;
        @(posedge sclk); #1;
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_rdy", req_ready, 1);

        for (int i = 0; i < 5; i++) begin
            run(tbl[i].pat, tbl[i].chg, tbl[i].stall, 1'b0, gc, gs);
            chk("tbl_cycles", gc, tbl[i].exp_cyc);
            chk("tbl_status", gs, 0);
        end

        for (int i = 0; i < 20; i++) begin
            logic [63:0] m;
            m = (64'd1 << $urandom_range(2, 30)) - 64'd1;
            run($urandom, {$urandom, $urandom} & m, $urandom_range(0, 3),
                1'b1, gc, gs);
        end

        req_valid = 1'b1;
        req_pattern = 8'h5A;
        @(posedge sclk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge sclk);
        #1;
        abort = 1'b1;
        @(posedge sclk); #1;
        abort = 1'b0;
        chk("abort_load", onn_load, 0);
        chk("abort_rst_n", onn_rst_n, 1);
        chk("abort_valid", res_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rdy", req_ready, 1);
        seen = 0;
        repeat (30) begin
            @(posedge sclk); #1;
            if (res_valid) seen++;
        end
        chk("abort_no_res", seen, 0);
        run(8'hC3, 64'h0, 0, 1'b0, gc, gs);
        chk("post_abort_cyc", gc, 5);

        req_valid = 1'b1;
        req_pattern = 8'h99;
        @(posedge sclk); #1;
        req_valid = 1'b0;
        repeat (13) @(posedge sclk);
        #2;
        re = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rst_n", onn_rst_n, 0);
        chk("mid_rst_rdy", req_ready, 1);
        chk("mid_rst_cyc", res_cycles, 0);
        repeat (2) @(posedge sclk);
        #1;
        re = 1'b1;
        @(posedge sclk); #1;
        chk("mid_rel_rst_n", onn_rst_n, 1);
        run(8'h0F, 64'h3C, 0, 1'b0, gc, gs);
        chk("post_rst_cyc", gc, 9);

`ifdef ONN_SEQ_TIMEOUT_EN
        run(8'h11, ~64'h0, 0, 1'b0, gc, gs);
        chk("tmo_cycles", gc, TMO);
        chk("tmo_status", gs, 1);
        run(8'h22, ((64'd1 << 29) - 64'd1) & ~64'd3, 0, 1'b0, gc, gs);
        chk("tie_cycles", gc, TMO);
        chk("tie_status", gs, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
